// File: rtl/hexseg_pkg.sv
// Shared constants for the hex seven-segment scanner: segment bit masks,
// the glyph table for nibbles 0..F, and a lookup helper.
package hexseg_pkg;

    // Segment masks as wired on the board connector
    localparam logic [6:0] SEG_B = 7'h01;
    localparam logic [6:0] SEG_G = 7'h02;
    localparam logic [6:0] SEG_C = 7'h04;
    localparam logic [6:0] SEG_F = 7'h08;
    localparam logic [6:0] SEG_A = 7'h10;
    localparam logic [6:0] SEG_D = 7'h20;
    localparam logic [6:0] SEG_E = 7'h40;

    // Glyphs for 0..F; lower-case b and d keep them distinct from 8 and 0
    localparam logic [6:0] HEX_GLYPH [16] = '{
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F,          // 0 -> 7D
        SEG_B | SEG_C,                                          // 1 -> 05
        SEG_A | SEG_B | SEG_G | SEG_E | SEG_D,                  // 2 -> 73
        SEG_A | SEG_B | SEG_G | SEG_C | SEG_D,                  // 3 -> 37
        SEG_F | SEG_G | SEG_B | SEG_C,                          // 4 -> 0F
        SEG_A | SEG_F | SEG_G | SEG_C | SEG_D,                  // 5 -> 3E
        SEG_A | SEG_F | SEG_G | SEG_E | SEG_C | SEG_D,          // 6 -> 7E
        SEG_A | SEG_B | SEG_C,                                  // 7 -> 15
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G,  // 8 -> 7F
        SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G,          // 9 -> 3F
        SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G,          // A -> 5F
        SEG_F | SEG_E | SEG_G | SEG_C | SEG_D,                  // b -> 6E
        SEG_A | SEG_F | SEG_E | SEG_D,                          // C -> 78
        SEG_B | SEG_C | SEG_D | SEG_E | SEG_G,                  // d -> 67
        SEG_A | SEG_F | SEG_G | SEG_E | SEG_D,                  // E -> 7A
        SEG_A | SEG_F | SEG_G | SEG_E                           // F -> 5A
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/hexseg_decode.sv
// Combinational nibble-to-glyph decoder; a blanked digit renders no segments.
module hexseg_decode
    import hexseg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);

    // Table lookup, forced dark when the digit is a suppressed leading zero
    always_comb begin
        glyph = blank ? 7'h00 : hex_glyph(nibble);
    end

endmodule

// File: rtl/hexseg_scan.sv
// Time-multiplexed driver for a bank of common-cathode seven-segment digits.
// A free-running slot counter walks the digits round-robin; each slot opens
// with a dead-time window so the previous digit's segments never ghost onto
// the next one. Loads land in a pending register and only reach the display
// register at the frame boundary, so a frame is never torn.
module hexseg_scan
    import hexseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned CLK_DIV      = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_n,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LIT  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          idx_q;

    logic [4*NUM_DIGITS-1:0]   pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]   disp_value_q, disp_value_d;
    logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic                      commit;

    logic [NUM_DIGITS-1:0]     lz_blank;
    logic                      above_zero;

    logic [3:0]                sel_nibble;
    logic                      sel_blank;
    logic                      sel_dp;
    logic [6:0]                glyph;
    logic                      lit;
    logic [NUM_DIGITS-1:0]     digit_n_d;

    // Slot counter and digit index; both run regardless of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Pending takes every load; display takes pending on the frame boundary,
    // and a load on that same edge bypasses straight through to display
    always_comb begin
        commit       = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
        pend_value_d = load ? value : pend_value_q;
        pend_dp_d    = load ? dp_in : pend_dp_q;
        disp_value_d = commit ? pend_value_d : disp_value_q;
        disp_dp_d    = commit ? pend_dp_d : disp_dp_q;
    end

    // Pending and display registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
        end else begin
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            disp_value_q <= disp_value_d;
            disp_dp_q    <= disp_dp_d;
        end
    end

    // Leading-zero chain from the top digit down; digit 0 always shows
    always_comb begin
        lz_blank   = '0;
        above_zero = 1'b1;
        if (LZ_BLANK != 0) begin
            for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
                above_zero  = above_zero & (disp_value_q[4*k +: 4] == 4'h0);
                lz_blank[k] = above_zero;
            end
        end
    end

    // Select the active digit's nibble/blank/dp and build the select pattern
    always_comb begin
        sel_nibble = 4'h0;
        sel_blank  = 1'b0;
        sel_dp     = 1'b0;
        digit_n_d  = '1;
        lit        = enable && (cnt_q >= CNT_LIT);
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_nibble   = disp_value_q[4*k +: 4];
                sel_blank    = lz_blank[k];
                sel_dp       = disp_dp_q[k];
                digit_n_d[k] = ~lit;
            end
        end
    end

    hexseg_decode u_decode (
        .nibble (sel_nibble),
        .blank  (sel_blank),
        .glyph  (glyph)
    );

    // Registered pins; dark during dead time or when disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            segment    <= '0;
            dp         <= 1'b0;
            digit_n    <= '1;
            frame_done <= 1'b0;
        end else begin
            segment    <= lit ? glyph : 7'h00;
            dp         <= lit & sel_dp;
            digit_n    <= digit_n_d;
            frame_done <= commit;
        end
    end

endmodule
